// File: rtl/mem_test_master.sv
// mem_test_master: Avalon-MM write/read-back memory tester driving an incrementing pattern.
// Defining MEM_TEST_FIRST_ERR_EN adds first_err_addr/first_err_data capture of the first mismatch.
module mem_test_master #(
  parameter int ADDR_W = 16,
  parameter int ERR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   length,
  input  logic [31:0]       seed,
  output logic [ADDR_W-1:0] address,
  output logic              chipselect,
  output logic              write,
  output logic              read,
  output logic [3:0]        byteenable,
  output logic [31:0]       writedata,
  input  logic              waitrequest,
  input  logic [31:0]       readdata,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  err_count
`ifdef MEM_TEST_FIRST_ERR_EN
  ,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [31:0]       first_err_data
`endif
);
  typedef enum logic [2:0] {IDLE, WR, RD, CMP, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W:0] idx_q, idx_d, len_q, len_d, idx_n;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d, addr_n;
  logic [31:0] seed_q, seed_d, wdata_q, wdata_d;
  logic cs_q, cs_d, wr_q, wr_d, rd_q, rd_d, busy_q, busy_d, done_q, done_d;
  logic [3:0] be_q, be_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic last, mismatch;
`ifdef MEM_TEST_FIRST_ERR_EN
  logic [ADDR_W-1:0] fe_addr_q, fe_addr_d;
  logic [31:0] fe_data_q, fe_data_d;
`endif
  assign idx_n = idx_q + 1'b1;
  assign addr_n = base_q + idx_n[ADDR_W-1:0];
  assign last = idx_q == len_q - 1'b1;
  assign mismatch = readdata != seed_q + 32'(idx_q);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    len_d = len_q;
    base_d = base_q;
    seed_d = seed_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    cs_d = cs_q;
    wr_d = wr_q;
    rd_d = rd_q;
    be_d = be_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d = err_q;
`ifdef MEM_TEST_FIRST_ERR_EN
    fe_addr_d = fe_addr_q;
    fe_data_d = fe_data_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        base_d = base;
        len_d = length;
        seed_d = seed;
        idx_d = '0;
        err_d = '0;
        busy_d = 1'b1;
`ifdef MEM_TEST_FIRST_ERR_EN
        fe_addr_d = '0;
        fe_data_d = '0;
`endif
        if (length != '0) begin
          state_d = WR;
          cs_d = 1'b1;
          wr_d = 1'b1;
          be_d = 4'hF;
          addr_d = base;
          wdata_d = seed;
        end else begin
          state_d = DONE;
          done_d = 1'b1;
        end
      end
      WR: if (!waitrequest) begin
        // after the last write, restart the index for the read-back pass
        idx_d = last ? '0 : idx_n;
        addr_d = last ? base_q : addr_n;
        wdata_d = seed_q + 32'(idx_n);
        wr_d = last ? 1'b0 : 1'b1;
        rd_d = last;
        state_d = last ? RD : WR;
      end
      RD: if (!waitrequest) begin
        state_d = CMP;
        cs_d = 1'b0;
        rd_d = 1'b0;
        be_d = 4'h0;
      end
      CMP: begin
        if (mismatch) begin
          err_d = (err_q == '1) ? err_q : err_q + 1'b1;
`ifdef MEM_TEST_FIRST_ERR_EN
          fe_addr_d = (err_q == '0) ? addr_q : fe_addr_q;
          fe_data_d = (err_q == '0) ? readdata : fe_data_q;
`endif
        end
        state_d = last ? DONE : RD;
        done_d = last;
        idx_d = last ? idx_q : idx_n;
        addr_d = last ? addr_q : addr_n;
        cs_d = !last;
        rd_d = !last;
        be_d = last ? 4'h0 : 4'hF;
      end
      DONE: begin
        state_d = IDLE;
        busy_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      len_q <= '0;
      base_q <= '0;
      seed_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      cs_q <= 1'b0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      be_q <= 4'h0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= '0;
`ifdef MEM_TEST_FIRST_ERR_EN
      fe_addr_q <= '0;
      fe_data_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      len_q <= len_d;
      base_q <= base_d;
      seed_q <= seed_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      cs_q <= cs_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      be_q <= be_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
`ifdef MEM_TEST_FIRST_ERR_EN
      fe_addr_q <= fe_addr_d;
      fe_data_q <= fe_data_d;
`endif
    end
  end
  assign address = addr_q;
  assign chipselect = cs_q;
  assign write = wr_q;
  assign read = rd_q;
  assign byteenable = be_q;
  assign writedata = wdata_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err_count = err_q;
`ifdef MEM_TEST_FIRST_ERR_EN
  assign first_err_addr = fe_addr_q;
  assign first_err_data = fe_data_q;
`endif
endmodule
